// File: rtl/tag_linked_list_store.sv
// Tag-ordered descriptor store: a singly linked list held in node memory,
// with a self-initialising free list that recycles popped nodes.
module tag_linked_list_store #(
    parameter int TAG_W  = 12,
    parameter int PID_W  = 13,
    parameter int SPB_W  = 8,
    parameter int ADDR_W = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ins_valid,
    output logic              ins_ready,
    input  logic [ADDR_W-1:0] ins_prev,
    input  logic [TAG_W-1:0]  ins_tag,
    input  logic [PID_W-1:0]  ins_pid,
    input  logic [SPB_W-1:0]  ins_spb,
    output logic              ins_done,
    output logic [ADDR_W-1:0] ins_addr,
    input  logic              pop_valid,
    output logic              pop_ready,
    output logic              pop_done,
    output logic [TAG_W-1:0]  pop_tag,
    output logic [PID_W-1:0]  pop_pid,
    output logic [SPB_W-1:0]  pop_spb,
    output logic [ADDR_W-1:0] head_addr,
    output logic [ADDR_W-1:0] count,
    output logic              full,
    output logic              empty,
    output logic              init_done
);
    localparam int DATA_W = TAG_W + PID_W + SPB_W;
    localparam int NODE_W = DATA_W + ADDR_W;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] NULL_ADDR = '0;
    localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);

    typedef enum logic [2:0] {INIT, IDLE, INS_WR1, INS_WR2, POP_WR} state_t;

    state_t            state;
    logic [ADDR_W-1:0] init_idx;
    logic [ADDR_W-1:0] init_next;
    logic [ADDR_W-1:0] free_head;
    logic [ADDR_W-1:0] data_head;

    logic [NODE_W-1:0] mem [DEPTH];
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [NODE_W-1:0] mem_wdata;

    logic              rd_en;
    logic [ADDR_W-1:0] rd_a_addr;
    logic [ADDR_W-1:0] rd_b_addr;
    logic [NODE_W-1:0] rd_a_p1;
    logic [NODE_W-1:0] rd_b_p1;
    logic [ADDR_W-1:0] prev_p1;
    logic [DATA_W-1:0] desc_p1;

    logic              is_idle;
    logic              ins_acc;
    logic              pop_acc;
    logic [ADDR_W-1:0] a_next;
    logic [ADDR_W-1:0] b_next;
    logic [DATA_W-1:0] a_data;
    logic [DATA_W-1:0] b_data;

    assign empty     = (count == NULL_ADDR);
    assign full      = (count == LAST_ADDR);
    assign head_addr = data_head;

    // Pop wins over a simultaneous insert; neither handshake completes in reset.
    assign is_idle   = (state == IDLE) && !rst;
    assign pop_ready = is_idle && !empty;
    assign ins_ready = is_idle && !full && !(pop_valid && !empty);
    assign pop_acc   = pop_valid && pop_ready;
    assign ins_acc   = ins_valid && ins_ready;

    assign init_next = init_idx + ONE;

    assign a_next = rd_a_p1[ADDR_W-1:0];
    assign a_data = rd_a_p1[NODE_W-1:ADDR_W];
    assign b_next = rd_b_p1[ADDR_W-1:0];
    assign b_data = rd_b_p1[NODE_W-1:ADDR_W];

    // Port A serves the free head (insert) or the list head (pop); port B the predecessor.
    assign rd_en     = ins_acc || pop_acc;
    assign rd_a_addr = pop_acc ? data_head : free_head;
    assign rd_b_addr = ins_prev;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Stage p1: read data and the latched insert request
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_a_p1 <= mem[rd_a_addr];
            rd_b_p1 <= mem[rd_b_addr];
        end
        if (ins_acc) begin
            prev_p1 <= ins_prev;
            desc_p1 <= {ins_tag, ins_pid, ins_spb};
        end
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = NULL_ADDR;
        mem_wdata = '0;
        if (!rst) begin
            case (state)
                INIT: begin
                    // init_next wraps to the null pointer on the last entry.
                    mem_we    = 1'b1;
                    mem_waddr = init_idx;
                    mem_wdata = {{DATA_W{1'b0}}, init_next};
                end
                INS_WR1: begin
                    mem_we    = 1'b1;
                    mem_waddr = free_head;
                    mem_wdata = {desc_p1, (prev_p1 == NULL_ADDR) ? data_head : b_next};
                end
                INS_WR2: begin
                    if (prev_p1 != NULL_ADDR) begin
                        mem_we    = 1'b1;
                        mem_waddr = prev_p1;
                        mem_wdata = {b_data, ins_addr};
                    end
                end
                POP_WR: begin
                    mem_we    = 1'b1;
                    mem_waddr = data_head;
                    mem_wdata = {a_data, free_head};
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= INIT;
            init_idx  <= ONE;
            init_done <= 1'b0;
            free_head <= NULL_ADDR;
            data_head <= NULL_ADDR;
            count     <= NULL_ADDR;
            ins_done  <= 1'b0;
            ins_addr  <= NULL_ADDR;
            pop_done  <= 1'b0;
            pop_tag   <= '0;
            pop_pid   <= '0;
            pop_spb   <= '0;
        end else begin
            ins_done <= 1'b0;
            pop_done <= 1'b0;
            case (state)
                INIT: begin
                    init_idx <= init_next;
                    if (init_idx == LAST_ADDR) begin
                        free_head <= ONE;
                        data_head <= NULL_ADDR;
                        init_done <= 1'b1;
                        state     <= IDLE;
                    end
                end
                IDLE: begin
                    if (pop_acc) begin
                        state <= POP_WR;
                    end else if (ins_acc) begin
                        state <= INS_WR1;
                    end
                end
                INS_WR1: begin
                    // Completion is reported here so ins_done lands two cycles after accept.
                    free_head <= a_next;
                    ins_addr  <= free_head;
                    ins_done  <= 1'b1;
                    count     <= count + ONE;
                    if (prev_p1 == NULL_ADDR) begin
                        data_head <= free_head;
                    end
                    state <= INS_WR2;
                end
                INS_WR2: begin
                    state <= IDLE;
                end
                POP_WR: begin
                    free_head <= data_head;
                    data_head <= a_next;
                    count     <= count - ONE;
                    {pop_tag, pop_pid, pop_spb} <= a_data;
                    pop_done  <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_tag_linked_list_store.sv
// Randomised scoreboard bench for tag_linked_list_store (ADDR_W=3) against a
// queue-based list/free-list reference model.
module tb_tag_linked_list_store;
    localparam int TAG_W  = 12;
    localparam int PID_W  = 13;
    localparam int SPB_W  = 8;
    localparam int ADDR_W = 3;
    localparam int CAP    = (1 << ADDR_W) - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              ins_valid, ins_ready, ins_done;
    logic [ADDR_W-1:0] ins_prev, ins_addr;
    logic [TAG_W-1:0]  ins_tag, pop_tag;
    logic [PID_W-1:0]  ins_pid, pop_pid;
    logic [SPB_W-1:0]  ins_spb, pop_spb;
    logic              pop_valid, pop_ready, pop_done;
    logic [ADDR_W-1:0] head_addr, count;
    logic              full, empty, init_done;

    always #5 clk = ~clk;

    tag_linked_list_store #(
        .TAG_W(TAG_W), .PID_W(PID_W), .SPB_W(SPB_W), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .rst(rst),
        .ins_valid(ins_valid), .ins_ready(ins_ready), .ins_prev(ins_prev),
        .ins_tag(ins_tag), .ins_pid(ins_pid), .ins_spb(ins_spb),
        .ins_done(ins_done), .ins_addr(ins_addr),
        .pop_valid(pop_valid), .pop_ready(pop_ready), .pop_done(pop_done),
        .pop_tag(pop_tag), .pop_pid(pop_pid), .pop_spb(pop_spb),
        .head_addr(head_addr), .count(count), .full(full), .empty(empty),
        .init_done(init_done)
    );

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [TAG_W-1:0]  tag;
        logic [PID_W-1:0]  pid;
        logic [SPB_W-1:0]  spb;
    } node_t;
    typedef struct {
        logic [ADDR_W-1:0] addr;
        int                cnt;
        logic [ADDR_W-1:0] head;
    } ins_exp_t;
    typedef struct {
        node_t             n;
        int                cnt;
        logic [ADDR_W-1:0] head;
    } pop_exp_t;

    node_t             lst[$];
    logic [ADDR_W-1:0] freel[$];
    ins_exp_t          exp_ins_q[$];
    pop_exp_t          exp_pop_q[$];
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: ordered list of live nodes plus a LIFO free list.
    function automatic logic [ADDR_W-1:0] model_head();
        if (lst.size() == 0) return '0;
        return lst[0].addr;
    endfunction

    task automatic model_reset();
        lst.delete();
        freel.delete();
        for (int i = 1; i <= CAP; i++) freel.push_back(ADDR_W'(i));
    endtask

    task automatic model_insert(input logic [ADDR_W-1:0] prev, input logic [TAG_W-1:0] tag,
                                input logic [PID_W-1:0] pid, input logic [SPB_W-1:0] spb);
        node_t    nd;
        ins_exp_t e;
        int       pos = 0;
        nd.addr = freel.pop_front();
        nd.tag = tag; nd.pid = pid; nd.spb = spb;
        if (prev != '0) begin
            for (int i = 0; i < lst.size(); i++) if (lst[i].addr == prev) pos = i + 1;
        end
        lst.insert(pos, nd);
        e.addr = nd.addr; e.cnt = lst.size(); e.head = model_head();
        exp_ins_q.push_back(e);
    endtask

    task automatic model_pop();
        pop_exp_t e;
        e.n = lst.pop_front();
        freel.push_front(e.n.addr);
        e.cnt = lst.size(); e.head = model_head();
        exp_pop_q.push_back(e);
    endtask

    function automatic logic [ADDR_W-1:0] pick_prev(input bit allow_zero);
        int k;
        if (lst.size() == 0) return '0;
        k = allow_zero ? int'($urandom_range(lst.size(), 0)) : int'($urandom_range(lst.size(), 1));
        if (k == 0) return '0;
        return lst[k-1].addr;
    endfunction

    // Monitor: every done pulse is matched against the head of its expectation queue.
    initial begin
        ins_exp_t ei;
        pop_exp_t ep;
        forever begin
            @(negedge clk);
            if (ins_done) begin
                if (exp_ins_q.size() == 0) check("ins_done_unexpected", 32'(ins_done), 0);
                else begin
                    ei = exp_ins_q.pop_front();
                    check("sb_ins_addr", 32'(ins_addr), 32'(ei.addr));
                    check("sb_ins_count", 32'(count), ei.cnt);
                    check("sb_ins_head", 32'(head_addr), 32'(ei.head));
                end
            end
            if (pop_done) begin
                if (exp_pop_q.size() == 0) check("pop_done_unexpected", 32'(pop_done), 0);
                else begin
                    ep = exp_pop_q.pop_front();
                    check("sb_pop_tag", 32'(pop_tag), 32'(ep.n.tag));
                    check("sb_pop_pid", 32'(pop_pid), 32'(ep.n.pid));
                    check("sb_pop_spb", 32'(pop_spb), 32'(ep.n.spb));
                    check("sb_pop_count", 32'(count), ep.cnt);
                    check("sb_pop_head", 32'(head_addr), 32'(ep.head));
                end
            end
        end
    end

    task automatic do_reset();
        int edges = 0;
        rst = 1'b1; ins_valid = 1'b0; pop_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ins_ready", 32'(ins_ready), 0);
        check("rst_pop_ready", 32'(pop_ready), 0);
        check("rst_ins_done", 32'(ins_done), 0);
        check("rst_pop_done", 32'(pop_done), 0);
        check("rst_ins_addr", 32'(ins_addr), 0);
        check("rst_pop_tag", 32'(pop_tag), 0);
        check("rst_pop_pid", 32'(pop_pid), 0);
        check("rst_pop_spb", 32'(pop_spb), 0);
        check("rst_head", 32'(head_addr), 0);
        check("rst_count", 32'(count), 0);
        check("rst_full", 32'(full), 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_init_done", 32'(init_done), 0);
        rst = 1'b0;
        model_reset();
        while (!init_done && edges < 40) begin
            @(negedge clk);
            edges++;
        end
        check("init_cycles", edges, CAP);
        check("init_empty", 32'(empty), 1);
        check("init_count", 32'(count), 0);
        check("init_head", 32'(head_addr), 0);
    endtask

    task automatic do_insert(input logic [ADDR_W-1:0] prev, input logic [TAG_W-1:0] tag,
                             input logic [PID_W-1:0] pid, input logic [SPB_W-1:0] spb);
        int waited = 0;
        @(negedge clk);
        ins_valid = 1'b1; ins_prev = prev; ins_tag = tag; ins_pid = pid; ins_spb = spb;
        #1;
        while (!ins_ready && waited < 50) begin
            @(negedge clk); #1;
            waited++;
        end
        if (!ins_ready) begin
            check("ins_accept_timeout", 32'(ins_ready), 1);
            ins_valid = 1'b0;
        end else begin
            model_insert(prev, tag, pid, spb);
            @(posedge clk); #1;
            ins_valid = 1'b0;
            @(negedge clk);
            check("ins_lat_t1", 32'(ins_done), 0);
            @(negedge clk);
            check("ins_lat_t2", 32'(ins_done), 1);
        end
    endtask

    task automatic do_pop();
        int waited = 0;
        @(negedge clk);
        pop_valid = 1'b1;
        #1;
        while (!pop_ready && waited < 50) begin
            @(negedge clk); #1;
            waited++;
        end
        if (!pop_ready) begin
            check("pop_accept_timeout", 32'(pop_ready), 1);
            pop_valid = 1'b0;
        end else begin
            model_pop();
            @(posedge clk); #1;
            pop_valid = 1'b0;
            @(negedge clk);
            check("pop_lat_t1", 32'(pop_done), 0);
            @(negedge clk);
            check("pop_lat_t2", 32'(pop_done), 1);
            #1;
            check("pop_ready_again", 32'(pop_ready), 32'(lst.size() != 0));
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [ADDR_W-1:0] p;
        ins_valid = 1'b0; pop_valid = 1'b0; ins_prev = '0;
        ins_tag = '0; ins_pid = '0; ins_spb = '0;
        model_reset();
        do_reset();

        // Ordered insert and pop by tag position
        do_insert(3'd0, 12'd5, 13'd100, 8'd10);
        check("t2_addr_a", 32'(ins_addr), 1);
        do_insert(3'd1, 12'd9, 13'd200, 8'd20);
        check("t2_addr_b", 32'(ins_addr), 2);
        do_insert(3'd1, 12'd7, 13'd300, 8'd30);
        check("t2_addr_c", 32'(ins_addr), 3);
        do_pop(); check("t2_pop_a", 32'(pop_tag), 5);
        do_pop(); check("t2_pop_b", 32'(pop_tag), 7);
        do_pop(); check("t2_pop_c", 32'(pop_tag), 9);
        check("t2_empty", 32'(empty), 1);

        // Pop on empty list is never accepted
        @(negedge clk);
        pop_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("empty_pop_ready", 32'(pop_ready), 0);
            check("empty_pop_done", 32'(pop_done), 0);
            @(negedge clk);
        end
        pop_valid = 1'b0;
        check("empty_count", 32'(count), 0);
        check("empty_head", 32'(head_addr), 0);

        // Fill to capacity, refuse insert, recycle popped node
        do_reset();
        do_insert(3'd0, TAG_W'($urandom), PID_W'($urandom), SPB_W'($urandom));
        for (int i = 0; i < CAP - 1; i++)
            do_insert(pick_prev(1'b0), TAG_W'($urandom), PID_W'($urandom), SPB_W'($urandom));
        @(negedge clk);
        check("full_flag", 32'(full), 1);
        check("full_count", 32'(count), CAP);
        ins_valid = 1'b1; ins_prev = '0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("full_ins_ready", 32'(ins_ready), 0);
            @(negedge clk);
        end
        ins_valid = 1'b0;
        check("full_count_hold", 32'(count), CAP);
        do_pop();
        do_insert(3'd0, 12'd42, 13'd42, 8'd42);
        check("recycled_addr", 32'(ins_addr), 1);
        check("refill_count", 32'(count), CAP);
        check("refill_full", 32'(full), 1);

        // Simultaneous insert and pop: pop first, insert two cycles later
        do_reset();
        do_insert(3'd0, 12'd11, 13'd1, 8'd1);
        do_insert(3'd1, 12'd22, 13'd2, 8'd2);
        @(negedge clk);
        ins_valid = 1'b1; ins_prev = '0; ins_tag = 12'd33; ins_pid = 13'd3; ins_spb = 8'd3;
        pop_valid = 1'b1;
        #1;
        check("sim_ins_ready_t0", 32'(ins_ready), 0);
        check("sim_pop_ready_t0", 32'(pop_ready), 1);
        model_pop();
        @(posedge clk); #1;
        pop_valid = 1'b0;
        @(negedge clk); #1;
        check("sim_ins_ready_t1", 32'(ins_ready), 0);
        @(negedge clk);
        check("sim_pop_done_t2", 32'(pop_done), 1);
        #1;
        check("sim_ins_ready_t2", 32'(ins_ready), 1);
        model_insert(3'd0, 12'd33, 13'd3, 8'd3);
        @(posedge clk); #1;
        ins_valid = 1'b0;
        @(negedge clk);
        check("sim_ins_done_t3", 32'(ins_done), 0);
        @(negedge clk);
        check("sim_ins_done_t4", 32'(ins_done), 1);
        check("sim_count", 32'(count), 2);

        // Reset during INS_WR1 aborts the insert
        @(negedge clk);
        ins_valid = 1'b1; ins_prev = '0; ins_tag = 12'd77;
        #1;
        check("abort_ins_ready", 32'(ins_ready), 1);
        @(posedge clk); #1;
        ins_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_no_done", 32'(ins_done), 0);
        do_reset();
        do_insert(3'd0, 12'd88, 13'd8, 8'd8);
        check("abort_next_addr", 32'(ins_addr), 1);

        // Random mix of inserts and pops
        for (int i = 0; i < 80; i++) begin
            if (lst.size() == 0 || (lst.size() < CAP && $urandom_range(1, 0) == 1)) begin
                p = pick_prev(1'b1);
                do_insert(p, TAG_W'($urandom), PID_W'($urandom), SPB_W'($urandom));
            end else begin
                do_pop();
            end
        end

        repeat (4) @(negedge clk);
        check("ins_queue_drained", 32'(exp_ins_q.size()), 0);
        check("pop_queue_drained", 32'(exp_pop_q.size()), 0);
        check("final_count", 32'(count), 32'(lst.size()));
        check("final_head", 32'(head_addr), 32'(model_head()));
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
